// File: rtl/door_idol_tracker.sv
// door_idol_tracker
// Tracks the hidden door / idol object of one level: hidden under a brick,
// revealed when the brick is blown away, then either unlocked (door, once all
// enemies are gone) or collected (idol, on touch).  A door finishes the level
// after the player stands on it for four consecutive video frames.
// Optional feature macro: DOOR_REVEAL_BLINK_EN -- blink the object for the
// first 64 frames after it is revealed.
module door_idol_tracker (
   input  logic       clk,
   input  logic       resetN,
   input  logic       level_start,
   input  logic       bitMap_sel,
   input  logic       start_of_frame,
   input  logic       brick_cleared,
   input  logic       player_hit,
   input  logic [3:0] enemies_left,
   output logic       obj_visible,
   output logic       door_open,
   output logic       level_done,
   output logic       idol_collected,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HIDDEN   = 3'd1,
      ST_REVEALED = 3'd2,
      ST_OPEN     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       type_q, type_d;        // 0 = door, 1 = idol
   logic [1:0] dwell_q, dwell_d;      // consecutive frames with the player on the door
   logic       obj_visible_q, obj_visible_d;
   logic       door_open_q, door_open_d;
   logic       level_done_q, level_done_d;
   logic       idol_collected_q, idol_collected_d;
   logic       blink_vis;             // blink phase allows drawing this cycle

   // Next-state logic; level_start overrides everything else
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      dwell_d = dwell_q;
      if (level_start) begin
         state_d = ST_HIDDEN;
         type_d  = bitMap_sel;
         dwell_d = 2'd0;
      end else begin
         case (state_q)
            ST_HIDDEN: begin
               // player_hit is deliberately not looked at until revealed
               if (brick_cleared) begin
                  state_d = ST_REVEALED;
               end
            end
            ST_REVEALED: begin
               if (type_q) begin
                  if (player_hit) begin
                     state_d = ST_DONE;
                  end
               end else if (enemies_left == 4'd0) begin
                  state_d = ST_OPEN;
               end
            end
            ST_OPEN: begin
               // Door never relocks on enemy respawn; only frames matter here
               if (start_of_frame) begin
                  if (player_hit) begin
                     if (dwell_q == 2'd3) begin
                        state_d = ST_DONE;
                     end else begin
                        dwell_d = dwell_q + 2'd1;
                     end
                  end else begin
                     dwell_d = 2'd0;
                  end
               end
            end
            default: begin
               // IDLE and DONE wait for level_start
            end
         endcase
      end
   end

`ifdef DOOR_REVEAL_BLINK_EN
   logic [5:0] blink_cnt_q, blink_cnt_d;
   logic       blink_act_q, blink_act_d;

   // Frame counter for the reveal blink: starts on reveal, runs 64 frames
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_act_d = blink_act_q;
      if (level_start) begin
         blink_cnt_d = 6'd0;
         blink_act_d = 1'b0;
      end else if (state_q == ST_HIDDEN && state_d == ST_REVEALED) begin
         blink_cnt_d = 6'd0;
         blink_act_d = 1'b1;
      end else if (blink_act_q && start_of_frame &&
                   (state_q == ST_REVEALED || state_q == ST_OPEN)) begin
         if (blink_cnt_q == 6'd63) begin
            blink_act_d = 1'b0;
         end else begin
            blink_cnt_d = blink_cnt_q + 6'd1;
         end
      end
      // Visible in even 8-frame groups, steady on once the blink is over
      blink_vis = !blink_act_d || !blink_cnt_d[3];
   end

   // Blink counter registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         blink_cnt_q <= 6'd0;
         blink_act_q <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_act_q <= blink_act_d;
      end
   end
`else
   // No blink: object is drawn steadily whenever revealed or open
   always_comb begin
      blink_vis = 1'b1;
   end
`endif

   // Outputs are registered alongside the state so they change with it
   always_comb begin
      obj_visible_d    = (state_d == ST_REVEALED || state_d == ST_OPEN) && blink_vis;
      door_open_d      = (state_d == ST_OPEN);
      level_done_d     = (state_q == ST_OPEN) && (state_d == ST_DONE);
      idol_collected_d = (state_q == ST_REVEALED) && (state_d == ST_DONE);
   end

   // State, type, dwell and output registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q          <= ST_IDLE;
         type_q           <= 1'b0;
         dwell_q          <= 2'd0;
         obj_visible_q    <= 1'b0;
         door_open_q      <= 1'b0;
         level_done_q     <= 1'b0;
         idol_collected_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         type_q           <= type_d;
         dwell_q          <= dwell_d;
         obj_visible_q    <= obj_visible_d;
         door_open_q      <= door_open_d;
         level_done_q     <= level_done_d;
         idol_collected_q <= idol_collected_d;
      end
   end

   assign obj_visible    = obj_visible_q;
   assign door_open      = door_open_q;
   assign level_done     = level_done_q;
   assign idol_collected = idol_collected_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_door_idol_tracker.sv
// Testbench for door_idol_tracker: directed scenarios followed by random
// stimulus, all compared against a level-progress model.
module tb_door_idol_tracker;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       level_start = 1'b0;
   logic       bitMap_sel = 1'b0;
   logic       start_of_frame = 1'b0;
   logic       brick_cleared = 1'b0;
   logic       player_hit = 1'b0;
   logic [3:0] enemies_left = 4'd0;
   logic       obj_visible, door_open, level_done, idol_collected;
   logic [2:0] state_dbg;

   int vectors = 0;
   int checks = 0;
   int miscompares = 0;

   // Model of level progress, in terms of what has happened so far
   bit in_level, is_idol, revealed, unlocked, finished;
   bit pulse_ld, pulse_ic;
   int run_len;       // consecutive frames with player on the open door
   int frames_shown;  // frames since reveal (blink build)

   door_idol_tracker dut (
      .clk(clk), .resetN(resetN), .level_start(level_start), .bitMap_sel(bitMap_sel),
      .start_of_frame(start_of_frame), .brick_cleared(brick_cleared),
      .player_hit(player_hit), .enemies_left(enemies_left),
      .obj_visible(obj_visible), .door_open(door_open), .level_done(level_done),
      .idol_collected(idol_collected), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_level = 0; is_idol = 0; revealed = 0; unlocked = 0; finished = 0;
      pulse_ld = 0; pulse_ic = 0; run_len = 0; frames_shown = 0;
   endtask

   task automatic model_step(input bit ls, input bit sel, input bit sof, input bit bc,
                             input bit ph, input int en);
      pulse_ld = 0;
      pulse_ic = 0;
      if (ls) begin
         in_level = 1; is_idol = sel; revealed = 0; unlocked = 0; finished = 0;
         run_len = 0; frames_shown = 0;
      end else if (in_level && !finished) begin
         if (revealed && sof && frames_shown < 64) frames_shown++;
         if (!revealed) begin
            if (bc) begin
               revealed = 1;
               frames_shown = 0;
            end
         end else if (is_idol) begin
            if (ph) begin
               finished = 1;
               pulse_ic = 1;
            end
         end else if (!unlocked) begin
            if (en == 0) unlocked = 1;
         end else if (sof) begin
            if (!ph) run_len = 0;
            else if (run_len >= 3) begin
               finished = 1;
               pulse_ld = 1;
            end else run_len++;
         end
      end
   endtask

   function automatic logic [2:0] exp_state();
      if (!in_level) return 3'd0;
      if (finished) return 3'd4;
      if (!revealed) return 3'd1;
      if (unlocked) return 3'd3;
      return 3'd2;
   endfunction

   function automatic logic exp_visible();
      bit shown = revealed && !finished;
`ifdef DOOR_REVEAL_BLINK_EN
      shown = shown && (frames_shown >= 64 || ((frames_shown / 8) % 2) == 0);
`endif
      return shown;
   endfunction

   task automatic check_all(input string ctx);
      check({ctx, ".state"}, {5'd0, state_dbg}, {5'd0, exp_state()});
      check({ctx, ".obj_visible"}, {7'd0, obj_visible}, {7'd0, exp_visible()});
      check({ctx, ".door_open"}, {7'd0, door_open}, {7'd0, unlocked && !finished && in_level});
      check({ctx, ".level_done"}, {7'd0, level_done}, {7'd0, pulse_ld});
      check({ctx, ".idol_collected"}, {7'd0, idol_collected}, {7'd0, pulse_ic});
   endtask

   // One clock: drive inputs just after an edge, advance model, check after next edge
   task automatic cycle(input string ctx, input bit ls, input bit sel, input bit sof,
                        input bit bc, input bit ph, input logic [3:0] en);
      level_start = ls; bitMap_sel = sel; start_of_frame = sof;
      brick_cleared = bc; player_hit = ph; enemies_left = en;
      model_step(ls, sel, sof, bc, ph, int'(en));
      @(posedge clk);
      #1;
      vectors++;
      check_all(ctx);
   endtask

   // One video frame: a start_of_frame cycle followed by a quiet cycle
   task automatic frame(input string ctx, input bit ph, input logic [3:0] en);
      cycle(ctx, 0, 0, 1, 0, ph, en);
      cycle(ctx, 0, 0, 0, 0, 0, en);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      resetN = 1'b1;

      // Idle ignores everything but level_start
      cycle("idle_ign", 0, 1, 1, 1, 1, 4'd0);

      // Door path: reveal with enemies alive, unlock when they are gone
      cycle("door_ls", 1, 0, 0, 0, 0, 4'd2);
      cycle("door_sel_ign", 0, 1, 0, 0, 0, 4'd2);
      cycle("door_reveal", 0, 0, 0, 1, 1, 4'd2);
      check("door_locked", {7'd0, door_open}, 8'd0);
      cycle("door_wait", 0, 0, 0, 0, 0, 4'd2);
      cycle("door_unlock", 0, 0, 0, 0, 0, 4'd0);
      check("door_open_now", {7'd0, door_open}, 8'd1);

      // Dwell: 3 hit frames, a miss, then 4 hits (respawn must not relock)
      for (int i = 0; i < 3; i++) frame("dwell_a", 1, 4'd3);
      frame("dwell_miss", 0, 4'd0);
      for (int i = 0; i < 3; i++) frame("dwell_b", 1, 4'd0);
      check("dwell_no_done", {5'd0, state_dbg}, 8'd3);
      cycle("dwell_fourth", 0, 0, 1, 0, 1, 4'd0);
      check("level_done_pulse", {7'd0, level_done}, 8'd1);
      cycle("done_hold", 0, 0, 1, 1, 1, 4'd0);
      check("level_done_once", {7'd0, level_done}, 8'd0);

      // Idol path: hit on the reveal cycle is ignored, next cycle collects
      cycle("idol_ls", 1, 1, 0, 0, 0, 4'd5);
      cycle("idol_reveal", 0, 0, 0, 1, 1, 4'd5);
      check("idol_revealed", {5'd0, state_dbg}, 8'd2);
      cycle("idol_collect", 0, 0, 0, 0, 1, 4'd5);
      check("idol_pulse", {7'd0, idol_collected}, 8'd1);
      cycle("idol_hold", 0, 0, 0, 0, 1, 4'd5);

      // Priority: level_start beats the finishing frame
      cycle("prio_ls", 1, 0, 0, 0, 0, 4'd0);
      cycle("prio_reveal", 0, 0, 0, 1, 0, 4'd0);
      cycle("prio_open", 0, 0, 0, 0, 0, 4'd0);
      for (int i = 0; i < 3; i++) frame("prio_dwell", 1, 4'd0);
      cycle("prio_hit", 1, 0, 1, 0, 1, 4'd0);
      check("prio_no_done", {7'd0, level_done}, 8'd0);
      check("prio_hidden", {5'd0, state_dbg}, 8'd1);

      // Asynchronous reset in OPEN takes effect before the next edge
      cycle("ar_reveal", 0, 0, 0, 1, 0, 4'd0);
      cycle("ar_open", 0, 0, 0, 0, 0, 4'd0);
      #2;
      resetN = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      resetN = 1'b1;
      cycle("post_reset_ign", 0, 0, 1, 1, 1, 4'd0);

`ifdef DOOR_REVEAL_BLINK_EN
      // Blink pattern over the 64 frames after reveal
      cycle("blink_ls", 1, 0, 0, 0, 0, 4'd1);
      cycle("blink_reveal", 0, 0, 0, 1, 0, 4'd1);
      for (int i = 0; i < 70; i++) frame("blink", 0, 4'd1);
`endif

      // Random stimulus
      for (int i = 0; i < 4000; i++) begin
         bit ls, sel, sof, bc, ph;
         logic [3:0] en;
         ls  = ($urandom_range(0, 79) == 0);
         sel = $urandom_range(0, 1) == 1;
         sof = ($urandom_range(0, 3) == 0);
         bc  = ($urandom_range(0, 7) == 0);
         ph  = ($urandom_range(0, 3) != 0);
         en  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         cycle("rand", ls, sel, sof, bc, ph, en);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/door_idol_tracker.md
DOOR_IDOL_TRACKER -- requirements
Module: door_idol_tracker

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; resetN  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: level_start  in  1  one-cycle pulse, new level begins; bitMap_sel  in  1  object type from placement stage (0=door, 1=idol).
REQ-003 SHALL have ports: start_of_frame  in  1  one-cycle pulse per video frame; brick_cleared  in  1  explosion removed the brick covering the object (level, any cycle).
REQ-004 SHALL have ports: player_hit  in  1  player overlaps the object (level, any cycle); enemies_left  in  4  live enemy count.
REQ-005 SHALL have outputs: obj_visible  out  1  draw enable for object bitmap; door_open  out  1  door unlocked; level_done  out  1  one-cycle pulse; idol_collected  out  1  one-cycle pulse; state_dbg  out  3  current state encoding.

Function
REQ-006 SHALL implement FSM states IDLE=0, HIDDEN=1, REVEALED=2, OPEN=3, DONE=4; state_dbg = current state.
REQ-007 SHALL latch bitMap_sel into an internal type register on level_start; later bitMap_sel changes ignored until next level_start.
REQ-008 SHALL move any state -> HIDDEN on level_start, clearing dwell counter, blink counter and all outputs; level_start has priority over every other input that cycle.
REQ-009 HIDDEN: obj_visible=0; brick_cleared=1 -> REVEALED next cycle; player_hit ignored in HIDDEN, including the cycle brick_cleared rises.
REQ-010 REVEALED, type idol: player_hit=1 -> DONE next cycle, idol_collected pulses high exactly one cycle on entry to DONE.
REQ-011 REVEALED, type door: stays locked while enemies_left != 0; enemies_left == 0 -> OPEN next cycle, door_open=1 from that cycle.
REQ-012 OPEN: 2-bit dwell counter increments on each start_of_frame where player_hit=1, clears to 0 on any start_of_frame where player_hit=0; counter saturates at 3.
REQ-013 OPEN: start_of_frame with player_hit=1 and dwell==3 (4th consecutive frame) -> DONE next cycle, level_done pulses one cycle on entry to DONE.
REQ-014 OPEN: enemies_left becoming nonzero (respawn) SHALL NOT relock; door_open stays 1 until DONE or level_start.
REQ-015 obj_visible=1 in REVEALED and OPEN, 0 in IDLE, HIDDEN, DONE (subject to REQ-021).
REQ-016 DONE: holds, all pulses low, door_open=0, until level_start; further player_hit/brick_cleared ignored.
REQ-017 level_done and idol_collected SHALL never both be high; each pulses at most once per level.
REQ-018 brick_cleared in REVEALED/OPEN/DONE SHALL have no effect.

Reset
REQ-019 resetN low SHALL asynchronously force state IDLE, type=0, dwell=0, blink counter=0, obj_visible=0, door_open=0, level_done=0, idol_collected=0.
REQ-020 IDLE SHALL ignore all inputs except level_start; reset mid-level discards progress, object stays invisible until level_start and re-reveal.

Configuration
REQ-021 Macro DOOR_REVEAL_BLINK_EN defined: on entry to REVEALED, 6-bit frame counter starts; obj_visible toggles every 8 start_of_frame pulses for 64 frames (first 8 frames visible), then steady 1; counter continues into OPEN if unfinished. Undefined: no counter, obj_visible steady 1 in REVEALED/OPEN.

Verification
REQ-022 Door path: level_start with bitMap_sel=0, brick_cleared, enemies_left=2 -> REVEALED, door_open=0; enemies_left=0 -> OPEN next cycle, door_open=1.
REQ-023 Dwell: in OPEN, player_hit high over 3 frames, low on 4th, high for 4 more -> level_done single pulse only after 4th consecutive high frame of the second run.
REQ-024 Idol path: bitMap_sel=1, brick_cleared and player_hit same cycle -> REVEALED only; player_hit next cycle -> idol_collected one pulse, state 4.
REQ-025 Priority: level_start coincident with player_hit in OPEN at dwell==3 -> HIDDEN, no level_done pulse.
REQ-026 Reset: resetN low asynchronously in OPEN -> all outputs 0, state 0 same cycle; with DOOR_REVEAL_BLINK_EN, obj_visible pattern 8 frames on / 8 off over 64 frames after reveal.
